// File: rtl/lcd_write_strobe.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_strobe
// Brief    : HD44780 write-cycle generator. Start/ready/done handshake,
//            programmable setup/pulse/hold/gap timing, RS and data drive,
//            4-bit (two nibble) or 8-bit transfer mode.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_strobe #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 12,
  parameter int HOLD_CYCLES  = 1,
  parameter int GAP_CYCLES   = 50,
  parameter int CNT_W        = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iMode4,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RS,
  output logic [7:0] oLCD_Data
);

  // A zero-length phase would make the down-counter wrap, so clamp to one.
  localparam int SETUP_EFF = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int PULSE_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
  localparam int HOLD_EFF  = (HOLD_CYCLES  < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_EFF   = (GAP_CYCLES   < 1) ? 1 : GAP_CYCLES;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_EFF - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             second;   // 1 while the low nibble is being sent
  logic             mode4;    // latched transfer mode
  logic [3:0]       lo_nib;   // latched low nibble for the second 4-bit cycle
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  // Write-cycle sequencer; every output is registered so E cannot glitch.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      second       <= 1'b0;
      mode4        <= 1'b0;
      lo_nib       <= 4'h0;
      oReady       <= 1'b1;
      oDone        <= 1'b0;
      oLCD_Enabled <= 1'b0;
      oLCD_RS      <= 1'b0;
      oLCD_Data    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          oDone        <= 1'b0;
          oLCD_Enabled <= 1'b0;
          if (iStart) begin
            // Capture the whole request; later input changes have no effect.
            mode4     <= iMode4;
            lo_nib    <= iData[3:0];
            oLCD_RS   <= iRS;
            oLCD_Data <= iMode4 ? {iData[7:4], 4'h0} : iData;
            second    <= 1'b0;
            cnt       <= SETUP_LOAD;
            oReady    <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_zero) begin
            oLCD_Enabled <= 1'b1;
            cnt          <= PULSE_LOAD;
            state        <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        PULSE: begin
          if (cnt_zero) begin
            oLCD_Enabled <= 1'b0;
            cnt          <= HOLD_LOAD;
            state        <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        HOLD: begin
          if (cnt_zero) begin
            if (!mode4 || second) begin
              oDone <= 1'b1;
              state <= DONE;
            end else begin
              // Low nibble goes out while E is low, well before the next pulse.
              oLCD_Data <= {lo_nib, 4'h0};
              cnt       <= GAP_LOAD;
              state     <= GAP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GAP: begin
          if (cnt_zero) begin
            second <= 1'b1;
            cnt    <= SETUP_LOAD;
            state  <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          oDone  <= 1'b0;
          oReady <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          oReady       <= 1'b1;
          oDone        <= 1'b0;
          oLCD_Enabled <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_strobe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_strobe
// Brief    : Self-checking bench for lcd_write_strobe. Records per-cycle
//            output traces and compares them against hand-computed tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_write_strobe;

  logic       clk = 1'b0;
  logic       rst;
  // default-parameter instance
  logic       start, mode4, rs;
  logic [7:0] data;
  logic       ready, done, e, lcd_rs;
  logic [7:0] lcd_data;
  // minimum-timing instance (gap of 0 is clamped to 1)
  logic       start2, mode42, rs2;
  logic [7:0] data2;
  logic       ready2, done2, e2, lcd_rs2;
  logic [7:0] lcd_data2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcd_write_strobe dut (
    .Clock(clk), .Reset(rst), .iStart(start), .iMode4(mode4), .iRS(rs),
    .iData(data), .oReady(ready), .oDone(done), .oLCD_Enabled(e),
    .oLCD_RS(lcd_rs), .oLCD_Data(lcd_data)
  );

  lcd_write_strobe #(
    .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(16)
  ) dut2 (
    .Clock(clk), .Reset(rst), .iStart(start2), .iMode4(mode42), .iRS(rs2),
    .iData(data2), .oReady(ready2), .oDone(done2), .oLCD_Enabled(e2),
    .oLCD_RS(lcd_rs2), .oLCD_Data(lcd_data2)
  );

  // packed observation: {E, done, ready, RS, data}
  function automatic logic [11:0] pk(input logic pe, input logic pd, input logic pr,
                                     input logic prs, input logic [7:0] pdat);
    return {pe, pd, pr, prs, pdat};
  endfunction

  typedef struct {
    int          tid;
    int          lo;
    int          hi;
    logic [11:0] exp;
  } seg_t;

  seg_t        tbl [0:12];
  logic [11:0] trace [0:199];

  task automatic check(input string name, input int cyc, input logic [11:0] act,
                       input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got E/done/rdy/rs/data=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
               name, cyc, act[11], act[10], act[9], act[8], act[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Accept a request on dut, then record n cycles (cycle 1 = after accept edge).
  // Inputs are scrambled after accept; iStart is re-pulsed in cycles s1/s2.
  task automatic do_xfer(input logic m4, input logic r, input logic [7:0] d,
                         input int n, input int s1, input int s2);
    @(negedge clk);
    start = 1'b1; mode4 = m4; rs = r; data = d;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      trace[c] = pk(e, done, ready, lcd_rs, lcd_data);
      start = (c == s1) || (c == s2);
      mode4 = ~m4; rs = ~r; data = ~d;
    end
    start = 1'b0;
  endtask

  task automatic check_trace(input int tid, input string name);
    for (int i = 0; i < 13; i++)
      if (tbl[i].tid == tid)
        for (int c = tbl[i].lo; c <= tbl[i].hi; c++)
          check(name, c, trace[c], tbl[i].exp);
  endtask

  initial begin
    // 8-bit write, 0x38, RS=0
    tbl[0]  = '{0,  1,  2, pk(0, 0, 0, 0, 8'h38)};
    tbl[1]  = '{0,  3, 14, pk(1, 0, 0, 0, 8'h38)};
    tbl[2]  = '{0, 15, 15, pk(0, 0, 0, 0, 8'h38)};
    tbl[3]  = '{0, 16, 16, pk(0, 1, 0, 0, 8'h38)};
    tbl[4]  = '{0, 17, 30, pk(0, 0, 1, 0, 8'h38)};
    // 4-bit write, 0xA5, RS=1
    tbl[5]  = '{1,  1,  2, pk(0, 0, 0, 1, 8'hA0)};
    tbl[6]  = '{1,  3, 14, pk(1, 0, 0, 1, 8'hA0)};
    tbl[7]  = '{1, 15, 15, pk(0, 0, 0, 1, 8'hA0)};
    tbl[8]  = '{1, 16, 67, pk(0, 0, 0, 1, 8'h50)};
    tbl[9]  = '{1, 68, 79, pk(1, 0, 0, 1, 8'h50)};
    tbl[10] = '{1, 80, 80, pk(0, 0, 0, 1, 8'h50)};
    tbl[11] = '{1, 81, 81, pk(0, 1, 0, 1, 8'h50)};
    tbl[12] = '{1, 82, 120, pk(0, 0, 1, 1, 8'h50)};

    rst = 1'b1;
    start = 1'b1; mode4 = 1'b0; rs = 1'b1; data = 8'hFF;
    start2 = 1'b1; mode42 = 1'b1; rs2 = 1'b1; data2 = 8'hFF;

    // reset held with start asserted: outputs stay at reset values
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("reset_dut", c, pk(e, done, ready, lcd_rs, lcd_data), pk(0, 0, 1, 0, 8'h00));
      check("reset_dut2", c, pk(e2, done2, ready2, lcd_rs2, lcd_data2), pk(0, 0, 1, 0, 8'h00));
    end
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("post_reset", c, pk(e, done, ready, lcd_rs, lcd_data), pk(0, 0, 1, 0, 8'h00));
    end

    do_xfer(1'b0, 1'b0, 8'h38, 30, -1, -1);
    check_trace(0, "wr8");

    do_xfer(1'b1, 1'b1, 8'hA5, 120, -1, -1);
    check_trace(1, "wr4");

    // stray starts in PULSE (cycle 5) and DONE (cycle 81) must be ignored
    do_xfer(1'b1, 1'b1, 8'hA5, 120, 5, 81);
    check_trace(1, "wr4_stray");

    // reset during the 5th PULSE cycle aborts the transfer
    @(negedge clk);
    start = 1'b1; mode4 = 1'b0; rs = 1'b1; data = 8'h38;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_pulse", 7, pk(e, done, ready, lcd_rs, lcd_data), pk(1, 0, 0, 1, 8'h38));
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset", 8, pk(e, done, ready, lcd_rs, lcd_data), pk(0, 0, 1, 0, 8'h00));
    rst = 1'b0;
    for (int c = 9; c < 109; c++) begin
      @(negedge clk);
      check("abort_idle", c, pk(e, done, ready, lcd_rs, lcd_data), pk(0, 0, 1, 0, 8'h00));
    end

    // minimum timing, 4-bit, start held: 9-cycle period per transfer
    begin
      int          p;
      int          rises;
      logic        prev_e;
      logic [11:0] exp;
      rises = 0; prev_e = 1'b0;
      @(negedge clk);
      start2 = 1'b1; mode42 = 1'b1; rs2 = 1'b1; data2 = 8'hC3;
      for (int c = 1; c <= 27; c++) begin
        @(negedge clk);
        p   = ((c - 1) % 9) + 1;
        exp = pk((p == 2) || (p == 6), p == 8, p == 9, 1'b1,
                 (p <= 3) ? 8'hC0 : 8'h30);
        check("b2b_min", c, pk(e2, done2, ready2, lcd_rs2, lcd_data2), exp);
        if (e2 && !prev_e) rises++;
        prev_e = e2;
      end
      start2 = 1'b0;
      n_checks++;
      if (rises != 6) begin
        n_fail++;
        $display("FAIL b2b_rises: got %0d E rising edges, expected 6", rises);
      end
    end

    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
